imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Upstream boot stage for the single-cycle RISC-V core.
- Accepts a little-endian byte stream over a valid/ready interface and assembles it into 32-bit words.
- Writes each word into the instruction memory's write port at consecutive word addresses.
- Holds the core in reset until the image is fully committed, then releases it.

Parameters:
ADDR_W, 10, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W words

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a load from word address 0
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_last  input  1  qualifies the final byte of the image (sampled only on accept)
s_ready  output  1  loader can accept a byte
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_waddr  output  ADDR_W  word address of the current write
imem_wdata  output  32  assembled word
core_reset_n  output  1  active-low reset to the core; low = core held
busy  output  1  high in LOAD
done  output  1  high in DONE
err_overflow  output  1  high in ERR
word_count  output  ADDR_W+1  number of words written in the current/last load

Behaviour:
- Reset values: state IDLE, s_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_reset_n=0, busy=0, done=0, err_overflow=0, word_count=0, byte_idx=0. All outputs are registered.
- States: IDLE, LOAD, DONE, ERR.
  - IDLE: start -> LOAD.
  - LOAD: accept of a byte with s_last -> DONE. Accept of a byte that would begin a new word when word_count==MAX_WORDS -> ERR.
  - DONE: start -> LOAD.
  - ERR: exits only via reset.
- Byte accept is s_valid && s_ready. s_ready is 1 exactly while in LOAD; it drops the cycle after the s_last accept.
- On entry to LOAD: word_count, byte_idx and the address counter clear to 0. core_reset_n goes 0 in the same cycle as busy rises.
- Byte assembly: byte_idx 0..3 maps to bits [7:0], [15:8], [23:16], [31:24]. byte_idx wraps 3->0.
- Write timing: accept of byte_idx 3, or accept with s_last at any byte_idx, gives imem_we=1 in the next cycle.
  - imem_wdata = assembled word; unfilled upper bytes on an s_last partial word are 0x00.
  - imem_waddr = word_count before the increment.
  - word_count increments in the same cycle imem_we is high.
- imem_we is a single-cycle pulse; at most one write per 4 accepted bytes, so no backpressure is needed during writes.
- Release sequence: s_last accepted at cycle N.
  - N+1: imem_we=1, state DONE, done=1, busy=0.
  - N+2: core_reset_n=1.
  - The core never runs while a write is pending.
- Start in LOAD or ERR is ignored. Start in DONE restarts the load: core_reset_n drops to 0 and the previous image is overwritten from address 0.
- s_valid outside LOAD is ignored; s_data and s_last are don't-care when not accepted.
- Overflow: after MAX_WORDS words are written without s_last, the next accepted byte enters ERR.
  - That byte is not written.
  - s_ready=0, err_overflow=1, core_reset_n stays 0.
- Reset asserted mid-load aborts the load: all state returns to reset values, and a pending imem_we is suppressed in the cycle after reset is sampled.

Test Plan:
- Reset then start, bytes 13,00,00,00 / B3,00,50,00 with s_last on the 8th byte -> imem_we at addr0=0x00000013 and addr1=0x005000B3; word_count=2; done=1; core_reset_n=1 two cycles after the last accept.
- Partial word: start, bytes 93,00,A0 with s_last on A0 -> single write addr0=0x00A00093; core released.
- Backpressure gaps: s_valid toggled every other cycle for 8 bytes -> same words and addresses as the contiguous case; no extra or missing imem_we.
- Overflow with ADDR_W=2: stream 17 bytes without s_last -> 4 writes (addr 0..3); ERR on the 17th byte; err_overflow=1; s_ready=0; core_reset_n=0; a later start has no effect.
- Reload: after DONE, pulse start and stream 4 bytes EF,BE,AD,DE + s_last -> core_reset_n falls in the cycle busy rises; addr0=0xDEADBEEF; word_count=1.
- Reset mid-load after 6 accepted bytes -> imem_we stays 0 after reset is sampled; all outputs return to reset values; core_reset_n=0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time image loader for the single-cycle RISC-V core. A little-endian
// byte stream arrives over a valid/ready handshake, is packed into 32-bit
// words and written to consecutive instruction-memory word addresses starting
// at 0. The core is held in reset until the whole image has been committed.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse that begins (or restarts) a load
//   s_valid/s_data/s_last/s_ready  byte stream handshake; s_last marks the
//                   final byte of the image
//   imem_we/imem_waddr/imem_wdata  instruction-memory write port
//   core_reset_n    active-low reset to the core (0 = core held)
//   busy/done/err_overflow  state flags for LOAD/DONE/ERR
//   word_count      words written in the current/last load
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WC_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                s_ready_q, s_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_reset_n_q, core_reset_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  // Partially assembled word; unfilled lanes stay 0 so a short final word
  // is zero-padded without extra logic.
  logic [31:0]         word_buf_q, word_buf_d;

  logic                accept_s;
  logic [31:0]         merged_s;

  assign accept_s = s_valid && s_ready_q;

  // Insert the incoming byte into its lane of the word buffer.
  always_comb begin
    merged_s = word_buf_q;
    case (byte_idx_q)
      2'd0:    merged_s[7:0]   = s_data;
      2'd1:    merged_s[15:8]  = s_data;
      2'd2:    merged_s[23:16] = s_data;
      2'd3:    merged_s[31:24] = s_data;
      default: merged_s        = word_buf_q;
    endcase
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_LOAD;
          imem_waddr_d = {ADDR_W{1'b0}};
          word_count_d = {(ADDR_W+1){1'b0}};
          byte_idx_d   = 2'd0;
          word_buf_d   = 32'h0000_0000;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          // A byte that would open a word beyond capacity is dropped.
          if ((byte_idx_q == 2'd0) && (word_count_q == MAX_WORDS)) begin
            state_d = ST_ERR;
          end else if ((byte_idx_q == 2'd3) || s_last) begin
            imem_we_d    = 1'b1;
            imem_waddr_d = word_count_q[ADDR_W-1:0];
            imem_wdata_d = merged_s;
            word_count_d = word_count_q + WC_ONE;
            byte_idx_d   = 2'd0;
            word_buf_d   = 32'h0000_0000;
            if (s_last) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            word_buf_d = merged_s;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d == ST_LOAD);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
    // Release only once DONE has been held for a cycle, i.e. after the final
    // write strobe has retired.
    core_reset_n_d = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset; reset also kills any
  // write that was about to be issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      s_ready_q      <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_waddr_q   <= {ADDR_W{1'b0}};
      imem_wdata_q   <= 32'h0000_0000;
      core_reset_n_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      word_count_q   <= {(ADDR_W+1){1'b0}};
      byte_idx_q     <= 2'd0;
      word_buf_q     <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      s_ready_q      <= s_ready_d;
      imem_we_q      <= imem_we_d;
      imem_waddr_q   <= imem_waddr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_reset_n_q <= core_reset_n_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      word_count_q   <= word_count_d;
      byte_idx_q     <= byte_idx_d;
      word_buf_q     <= word_buf_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_reset_n = core_reset_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader built with ADDR_W=2 (4-word capacity) so
// the overflow path is reachable with a short stream. A negedge monitor logs
// every write strobe; each scenario compares the log and the status outputs
// against hand-computed values.
module tb_imem_loader;

  localparam int ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_reset_n;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic [ADDR_W:0]   word_count;

  int tests_run;
  int tests_failed;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_reset_n (core_reset_n),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back({{(32-ADDR_W){1'b0}}, imem_waddr});
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'hFF;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check_eq({pfx, "_we"}, {31'd0, imem_we}, 32'd0);
    check_eq({pfx, "_waddr"}, {30'd0, imem_waddr}, 32'd0);
    check_eq({pfx, "_wdata"}, imem_wdata, 32'd0);
    check_eq({pfx, "_core_rst_n"}, {31'd0, core_reset_n}, 32'd0);
    check_eq({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({pfx, "_done"}, {31'd0, done}, 32'd0);
    check_eq({pfx, "_err"}, {31'd0, err_overflow}, 32'd0);
    check_eq({pfx, "_wc"}, {29'd0, word_count}, 32'd0);
  endtask

  // Two words with the final byte closing word 1; used for both the
  // contiguous and the gapped stream.
  task automatic check_two_word_image(input string pfx);
    check_eq({pfx, "_nwr"}, wr_data.size(), 32'd2);
    check_eq({pfx, "_a0"}, wr_addr[0], 32'd0);
    check_eq({pfx, "_d0"}, wr_data[0], 32'h0000_0013);
    check_eq({pfx, "_a1"}, wr_addr[1], 32'd1);
    check_eq({pfx, "_d1"}, wr_data[1], 32'h0050_00B3);
  endtask

  logic [7:0] img8 [8];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    img8[0] = 8'h13; img8[1] = 8'h00; img8[2] = 8'h00; img8[3] = 8'h00;
    img8[4] = 8'hB3; img8[5] = 8'h00; img8[6] = 8'h50; img8[7] = 8'h00;

    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;

    // s_valid in IDLE must be ignored.
    send(8'h55, 1'b1);
    check_eq("idle_ignore_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_ignore_nwr", wr_data.size(), 32'd0);

    // Contiguous two-word image.
    clear_log();
    pulse_start();
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    check_eq("t1_ready", {31'd0, s_ready}, 32'd1);
    check_eq("t1_core_held", {31'd0, core_reset_n}, 32'd0);
    for (int i = 0; i < 8; i++) send(img8[i], (i == 7));
    check_eq("t1_we_n1", {31'd0, imem_we}, 32'd1);
    check_eq("t1_done_n1", {31'd0, done}, 32'd1);
    check_eq("t1_busy_n1", {31'd0, busy}, 32'd0);
    check_eq("t1_ready_n1", {31'd0, s_ready}, 32'd0);
    check_eq("t1_core_n1", {31'd0, core_reset_n}, 32'd0);
    check_eq("t1_wc", {29'd0, word_count}, 32'd2);
    tick();
    check_eq("t1_core_n2", {31'd0, core_reset_n}, 32'd1);
    check_eq("t1_we_n2", {31'd0, imem_we}, 32'd0);
    check_two_word_image("t1");

    // Partial final word, started from DONE.
    clear_log();
    pulse_start();
    check_eq("t2_busy", {31'd0, busy}, 32'd1);
    check_eq("t2_core_drop", {31'd0, core_reset_n}, 32'd0);
    send(8'h93, 1'b0);
    send(8'h00, 1'b0);
    send(8'hA0, 1'b1);
    check_eq("t2_wc", {29'd0, word_count}, 32'd1);
    tick();
    check_eq("t2_core", {31'd0, core_reset_n}, 32'd1);
    check_eq("t2_nwr", wr_data.size(), 32'd1);
    check_eq("t2_a0", wr_addr[0], 32'd0);
    check_eq("t2_d0", wr_data[0], 32'h00A0_0093);

    // Same image as the first load with an idle cycle after every byte.
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send(img8[i], (i == 7));
      if (i != 7) tick();
    end
    check_eq("t3_done", {31'd0, done}, 32'd1);
    check_eq("t3_wc", {29'd0, word_count}, 32'd2);
    tick();
    tick();
    check_eq("t3_core", {31'd0, core_reset_n}, 32'd1);
    check_two_word_image("t3");

    // Reload of a single full word terminated on byte lane 3.
    clear_log();
    pulse_start();
    check_eq("t5_busy", {31'd0, busy}, 32'd1);
    check_eq("t5_core_drop", {31'd0, core_reset_n}, 32'd0);
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hDE, 1'b1);
    check_eq("t5_wc", {29'd0, word_count}, 32'd1);
    tick();
    check_eq("t5_core", {31'd0, core_reset_n}, 32'd1);
    check_eq("t5_nwr", wr_data.size(), 32'd1);
    check_eq("t5_a0", wr_addr[0], 32'd0);
    check_eq("t5_d0", wr_data[0], 32'hDEAD_BEEF);

    // Overflow: 16 bytes fill all four words, the 17th byte trips ERR.
    clear_log();
    pulse_start();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    tick();
    check_eq("t4_wc_full", {29'd0, word_count}, 32'd4);
    check_eq("t4_nwr", wr_data.size(), 32'd4);
    for (int w = 0; w < 4; w++) begin
      check_eq($sformatf("t4_a%0d", w), wr_addr[w], 32'(w));
      check_eq($sformatf("t4_d%0d", w), wr_data[w],
               32'h0302_0100 + 32'(w) * 32'h0404_0404);
    end
    send(8'hAA, 1'b1);
    check_eq("t4_err", {31'd0, err_overflow}, 32'd1);
    check_eq("t4_ready", {31'd0, s_ready}, 32'd0);
    check_eq("t4_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_core", {31'd0, core_reset_n}, 32'd0);
    tick();
    check_eq("t4_nwr_after", wr_data.size(), 32'd4);
    pulse_start();
    tick();
    check_eq("t4_start_err", {31'd0, err_overflow}, 32'd1);
    check_eq("t4_start_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_start_ready", {31'd0, s_ready}, 32'd0);

    // Reset mid-load: a write that the colliding s_last would cause is lost.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_log();
    pulse_start();
    for (int i = 0; i < 6; i++) send(img8[i], 1'b0);
    check_eq("t6_nwr_pre", wr_data.size(), 32'd1);
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h50;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_reset_vals("t6");
    reset = 1'b0;
    tick();
    check_eq("t6_we_after", {31'd0, imem_we}, 32'd0);
    check_eq("t6_nwr_post", wr_data.size(), 32'd1);
    check_eq("t6_core", {31'd0, core_reset_n}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
